// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;
  localparam int DEF_PARALLELISM = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when the shifted remainder is not below it.
module div_step
  import div_pkg::*;
#(
  parameter int parallelism = DEF_PARALLELISM
) (
  input  logic [parallelism-1:0] prem,
  input  logic [parallelism-1:0] divisor,
  input  logic                   nbit,
  output logic [parallelism-1:0] prem_nx,
  output logic                   qbit
);
  logic [parallelism:0] shifted;

  // The incoming remainder is always below the divisor, so the result of the
  // subtraction fits back into N bits and modulo-N arithmetic is exact.
  always_comb begin
    shifted = {prem, nbit};
    qbit    = (shifted >= {1'b0, divisor});
    prem_nx = qbit ? (shifted[parallelism-1:0] - divisor) : shifted[parallelism-1:0];
  end
endmodule

// File: rtl/sequential_divider.sv
// 2N/N unsigned sequential divider, one restoring step per cycle, with
// early overflow / divide-by-zero detection and a valid/ready result port.
module sequential_divider
  import div_pkg::*;
#(
  parameter int parallelism = DEF_PARALLELISM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*parallelism-1:0]   dividend,
  input  logic [parallelism-1:0]     divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [parallelism-1:0]     quotient,
  output logic [parallelism-1:0]     remainder,
  output logic                       overflow,
  output logic                       div_by_zero
);
  localparam int N  = parallelism;
  localparam int CW = $clog2(N) + 1;

  state_t         state, state_nx;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   prem, dvs, dlo, quo;
  logic           ovf, dbz;
  logic [N-1:0]   step_rem;
  logic           step_q;
  logic           ovf_in, last;

  // If the high half already reaches the divisor the quotient cannot fit in
  // N bits; divisor == 0 falls out of the same compare.
  assign ovf_in = (dividend[2*N-1:N] >= divisor);
  assign last   = (cnt == CW'(N - 1));

  div_step #(.parallelism(N)) u_step (
    .prem    (prem),
    .divisor (dvs),
    .nbit    (dlo[N-1]),
    .prem_nx (step_rem),
    .qbit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = ovf_in ? DONE : CALC;
      CALC:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      prem <= '0;
      dvs  <= '0;
      dlo  <= '0;
      quo  <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvs <= divisor;
          dlo <= dividend[N-1:0];
          cnt <= '0;
          if (ovf_in) begin
            prem <= '0;
            quo  <= '1;
            ovf  <= 1'b1;
            dbz  <= (divisor == '0);
          end else begin
            prem <= dividend[2*N-1:N];
            quo  <= '0;
            ovf  <= 1'b0;
            dbz  <= 1'b0;
          end
        end
        CALC: begin
          prem <= step_rem;
          dlo  <= {dlo[N-2:0], 1'b0};
          quo  <= {quo[N-2:0], step_q};
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = out_valid ? quo  : '0;
  assign remainder   = out_valid ? prem : '0;
  assign overflow    = out_valid & ovf;
  assign div_by_zero = out_valid & dbz;
endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops and
// compares them, including result latency and output hold under stalls.
module tb_sequential_divider;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ovf;
    logic         dbz;
    int           acc;
    int           lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N-1:0]   quotient, remainder;
  logic           overflow, div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;   // 0 random, 1 held low, 2 held high
  exp_t sbq[$];

  sequential_divider #(.parallelism(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer division; anything not fitting in N bits is overflow.
  function automatic exp_t model(input logic [2*N-1:0] dd, input logic [N-1:0] ds, input int acc);
    exp_t e;
    int unsigned a = dd;
    int unsigned b = ds;
    int unsigned qmax = (1 << N) - 1;
    e.acc = acc;
    if (b == 0 || (a / b) > qmax) begin
      e.q = '1; e.r = '0; e.ovf = 1'b1; e.dbz = (b == 0); e.lat = 1;
    end else begin
      e.q = N'(a / b); e.r = N'(a % b); e.ovf = 1'b0; e.dbz = 1'b0; e.lat = N + 1;
    end
    return e;
  endfunction

  // Call just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] ds);
    int t = 0;
    dividend = dd;
    divisor  = ds;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout dividend=%h divisor=%h in_ready=%b required 1", dd, ds, in_ready);
    end else begin
      sbq.push_back(model(dd, ds, cyc + 1));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor
  initial begin
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result q=%h r=%h ovf=%b dbz=%b required no result", quotient, remainder, overflow, div_by_zero);
          end else begin
            if (!seen) begin
              checks++;
              if (cyc - sbq[0].acc + 1 != sbq[0].lat) begin
                errors++;
                $display("FAIL latency got %0d required %0d", cyc - sbq[0].acc + 1, sbq[0].lat);
              end
              seen = 1;
            end
            checks++;
            if ({quotient, remainder, overflow, div_by_zero} !== {sbq[0].q, sbq[0].r, sbq[0].ovf, sbq[0].dbz}) begin
              errors++;
              $display("FAIL result q=%h r=%h ovf=%b dbz=%b required q=%h r=%h ovf=%b dbz=%b",
                       quotient, remainder, overflow, div_by_zero, sbq[0].q, sbq[0].r, sbq[0].ovf, sbq[0].dbz);
            end
            if (out_ready) begin
              void'(sbq.pop_front());
              seen = 0;
            end
          end
        end else begin
          checks++;
          if ({quotient, remainder, overflow, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL idle_outputs q=%h r=%h ovf=%b dbz=%b required all 0", quotient, remainder, overflow, div_by_zero);
          end
        end
      end
    end
  end

  initial begin
    logic [2*N-1:0] dd;
    logic [N-1:0]   ds;
    int             t;

    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        {quotient, remainder, overflow, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b q=%h r=%h required 1 0 0 0", in_ready, out_valid, quotient, remainder);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases, including overflow boundaries
    rdy_mode = 2;
    issue(16'h0064, 8'h07);
    issue(16'hFE01, 8'hFF);
    issue(16'hFFFF, 8'hFF);
    issue(16'h1234, 8'h00);
    issue(16'h0000, 8'h01);
    issue(16'h00FF, 8'h01);
    issue(16'h0100, 8'h01);
    issue(16'h0000, 8'h00);

    // Backpressure with a competing request held on the input
    rdy_mode = 1;
    issue(16'h0064, 8'h07);
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 50);
    @(posedge clk);
    #1;
    dividend = 16'h0ABC; divisor = 8'h33; in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall in_ready=%b out_valid=%b required 0 1", in_ready, out_valid);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    rdy_mode = 2;
    issue(16'h0ABC, 8'h33);

    // Reset while computing
    issue(16'h1000, 8'h41);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    issue(16'h1000, 8'h41);

    // Random operands with random result stalls
    rdy_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      ds = N'($urandom_range(0, (1 << N) - 1));
      if (ds != 0 && $urandom_range(3) != 0)
        dd = {N'($urandom_range(0, int'(ds) - 1)), N'($urandom)};
      else
        dd = (2*N)'($urandom);
      issue(dd, ds);
    end

    rdy_mode = 2;
    t = 0;
    while (sbq.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sbq.size());
    end
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
